// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding
// and the helper that sizes the iteration counter.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH+1 (the iteration count loaded on start).
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then a one-bit arithmetic right shift across
// {acc, mr, q_m1}. Purely combinational; all operands are WIDTH+1 bits.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] mr,
  input  logic           q_m1,
  input  logic [WIDTH:0] md,
  output logic [WIDTH:0] acc_next,
  output logic [WIDTH:0] mr_next,
  output logic           q_m1_next
);

  logic [WIDTH:0] sum_s;

  // Booth recoding of {mr[0], q_m1}; arithmetic wraps modulo 2^(WIDTH+1).
  always_comb begin
    sum_s = acc;
    case ({mr[0], q_m1})
      2'b10:   sum_s = acc + (~md) + {{WIDTH{1'b0}}, 1'b1};
      2'b01:   sum_s = acc + md;
      default: sum_s = acc;
    endcase
  end

  // Arithmetic right shift of the concatenated {sum, mr, q_m1} by one bit.
  always_comb begin
    acc_next  = {sum_s[WIDTH], sum_s[WIDTH:1]};
    mr_next   = {sum_s[0], mr[WIDTH:1]};
    q_m1_next = mr[0];
  end

endmodule

// File: rtl/booth_mult_par.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Operands are extended to WIDTH+1 bits so one datapath covers both modes;
// WIDTH+1 iterations produce the full product, of which the low 2*WIDTH
// bits are published on the final iteration.
module booth_mult_par
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     mr_in,
  input  logic [WIDTH-1:0]     md_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     mr_q, mr_d;
  logic [WIDTH:0]     md_q, md_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     acc_nx_s;
  logic [WIDTH:0]     mr_nx_s;
  logic               qm1_nx_s;
  logic               last_iter_s;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_q),
    .mr        (mr_q),
    .q_m1      (qm1_q),
    .md        (md_q),
    .acc_next  (acc_nx_s),
    .mr_next   (mr_nx_s),
    .q_m1_next (qm1_nx_s)
  );

  assign last_iter_s = (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath next-state: load extended operands on start, step in RUN.
  always_comb begin
    acc_d     = acc_q;
    mr_d      = mr_q;
    md_d      = md_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          mr_d  = {is_signed & mr_in[WIDTH-1], mr_in};
          md_d  = {is_signed & md_in[WIDTH-1], md_in};
          qm1_d = 1'b0;
          cnt_d = CW'(WIDTH + 1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        acc_d = acc_nx_s;
        mr_d  = mr_nx_s;
        qm1_d = qm1_nx_s;
        cnt_d = cnt_q - CW'(1);
        if (last_iter_s) begin
          product_d = {acc_nx_s[WIDTH-2:0], mr_nx_s};
        end else begin
          product_d = product_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything including the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mr_q      <= '0;
      md_q      <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mr_q      <= mr_d;
      md_q      <= md_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_par.sv
// Self-checking bench: directed and random multiplies on a WIDTH=8 instance,
// plus concurrent random sweeps on WIDTH=2, 4 and 16 instances, all checked
// against an arithmetic reference product.
module tb_booth_mult_par;

  logic clk;
  logic rst_n;
  logic rst8_n;
  int   checks;
  int   failures;
  int   sweep_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    logic [63:0] m;
    x = longint'({32'd0, a});
    y = longint'({32'd0, b});
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & m;
  endfunction

  // ---------------- WIDTH = 8 instance ----------------
  logic        st8, sg8, rdy8, bsy8, dn8;
  logic [7:0]  mr8, md8;
  logic [15:0] pr8;

  booth_mult_par #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .start     (st8),
    .is_signed (sg8),
    .mr_in     (mr8),
    .md_in     (md8),
    .ready     (rdy8),
    .busy      (bsy8),
    .done      (dn8),
    .product   (pr8)
  );

  // One multiply on the WIDTH=8 instance. chaos disturbs inputs during RUN.
  task automatic do_op8(input string tag, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic chaos, input logic [15:0] exp);
    int lat;
    int bz;
    logic [15:0] prev;
    @(negedge clk);
    check_eq({tag, "_ready"}, 64'(rdy8), 64'd1);
    prev = pr8;
    st8 = 1'b1; sg8 = s; mr8 = a; md8 = b;
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    lat = 0;
    bz = 0;
    while (dn8 !== 1'b1 && lat < 30) begin
      if (bsy8 === 1'b1) bz++;
      if (lat == 4) check_eq({tag, "_hold"}, 64'(pr8), 64'(prev));
      if (chaos && lat == 2) begin
        st8 = 1'b1; mr8 = ~a; md8 = b ^ 8'h55; sg8 = ~s;
        check_eq({tag, "_rdy_run"}, 64'(rdy8), 64'd0);
      end
      if (chaos && lat == 3) st8 = 1'b0;
      @(negedge clk);
      lat++;
    end
    st8 = 1'b0;
    check_eq({tag, "_lat"}, 64'(lat), 64'd9);
    check_eq({tag, "_busy"}, 64'(bz), 64'd9);
    check_eq({tag, "_prod"}, 64'(pr8), 64'(exp));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(dn8), 64'd0);
  endtask

  initial begin
    int lat;
    int waited;
    int ndone;
    logic [7:0] a, b;
    logic s, c;
    checks = 0; failures = 0; sweep_fin = 0;
    rst_n = 1'b0; rst8_n = 1'b0;
    st8 = 1'b0; sg8 = 1'b0; mr8 = 8'h00; md8 = 8'h00;
    #1;
    check_eq("rst_ready", 64'(rdy8), 64'd1);
    check_eq("rst_busy", 64'(bsy8), 64'd0);
    check_eq("rst_done", 64'(dn8), 64'd0);
    check_eq("rst_prod", 64'(pr8), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rst8_n = 1'b1;

    do_op8("m3x5", 1'b1, 8'hFD, 8'h05, 1'b0, 16'hFFF1);
    do_op8("u255sq", 1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    do_op8("sm1sq", 1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0001);
    do_op8("s128sq", 1'b1, 8'h80, 8'h80, 1'b0, 16'h4000);
    do_op8("s128x127", 1'b1, 8'h80, 8'h7F, 1'b0, 16'hC080);
    do_op8("zero", 1'b1, 8'h00, 8'h5A, 1'b0, 16'h0000);
    do_op8("chaos", 1'b1, 8'hFD, 8'h05, 1'b1, 16'hFFF1);

    // Abort on the 4th RUN cycle.
    @(negedge clk);
    st8 = 1'b1; sg8 = 1'b0; mr8 = 8'h12; md8 = 8'h34;
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    lat = 0;
    while (lat < 3) begin
      @(negedge clk);
      lat++;
    end
    rst8_n = 1'b0;
    #1;
    check_eq("abort_prod", 64'(pr8), 64'd0);
    check_eq("abort_busy", 64'(bsy8), 64'd0);
    check_eq("abort_ready", 64'(rdy8), 64'd1);
    check_eq("abort_done", 64'(dn8), 64'd0);
    @(negedge clk);
    rst8_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn8 === 1'b1) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    check_eq("abort_prod_after", 64'(pr8), 64'd0);
    do_op8("post_abort", 1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080);

    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      s = 1'($urandom());
      c = 1'($urandom());
      do_op8("rnd8", s, a, b, c, 16'(ref_mul(8, s, 32'(a), 32'(b))));
    end

    waited = 0;
    while (sweep_fin < 3 && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("sweep_end", 64'(sweep_fin), 64'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- WIDTH = 2, 4, 16 sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
    logic           st, sg, rd, bz, dn;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] pr;

    booth_mult_par #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (st),
      .is_signed (sg),
      .mr_in     (a),
      .md_in     (b),
      .ready     (rd),
      .busy      (bz),
      .done      (dn),
      .product   (pr)
    );

    initial begin
      int lat;
      logic [W-1:0] ka, kb;
      logic ks;
      st = 1'b0; sg = 1'b0; a = '0; b = '0;
      wait (rst_n === 1'b1);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        check_eq($sformatf("w%0d_ready", W), 64'(rd), 64'd1);
        ka = W'($urandom());
        kb = W'($urandom());
        ks = 1'($urandom());
        a = ka; b = kb; sg = ks; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        lat = 0;
        while (dn !== 1'b1 && lat < 3 * W + 10) begin
          if (lat == 1) begin
            a = W'($urandom()); b = W'($urandom()); sg = ~ks; st = 1'($urandom());
          end
          if (lat == 2) st = 1'b0;
          @(negedge clk);
          lat++;
        end
        check_eq($sformatf("w%0d_lat", W), 64'(lat), 64'(W + 1));
        check_eq($sformatf("w%0d_prod a=%0h b=%0h s=%0d", W, ka, kb, ks), 64'(pr),
                 ref_mul(W, ks, 32'(ka), 32'(kb)));
      end
      sweep_fin++;
    end
  end

endmodule
